unidade_controle_multiciclo: RTL and testbench

Multicycle control FSM for the RISC-V core: sequences the shared datapath (single memory port, one ALU, instruction register, ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select from a registered state plus the decoded instruction fields. It stalls on a memory-ready handshake and traps illegal instructions into a sticky error state.

---
 rtl/unidade_controle_multiciclo.sv | 198 +++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RISC-V core: steps the shared datapath through
// fetch/decode/execute/memory/writeback and traps illegal encodings into ERROR.
module unidade_controle_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= FETCH;
        else
            r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next     = r_state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = DECODE;
                end
            end
            DECODE: begin
                // OldPC + imm is precomputed into ALUOut for branches and JAL
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECUTER;
                    OP_ITYPE:          w_next = EXECUTEI;
                    OP_BRANCH:         w_next = BRANCH;
                    OP_JAL:            w_next = JAL;
                    default:           w_next = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready)
                    w_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                w_next  = ALUWB;
                case ({funct7, funct3})
                    10'b0000000_000: ALUControl = ALU_ADD;
                    10'b0100000_000: ALUControl = ALU_SUB;
                    10'b0000000_111: ALUControl = ALU_AND;
                    10'b0000000_110: ALUControl = ALU_OR;
                    default:         w_next     = ERROR;
                endcase
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = ALUWB;
                case (funct3)
                    3'b000:  ALUControl = ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    default: w_next     = ERROR;
                endcase
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                w_next     = FETCH;
                case (funct3)
                    3'b000: begin
                        PCWrite    = zero;
                        instr_done = 1'b1;
                    end
                    3'b001: begin
                        PCWrite    = ~zero;
                        instr_done = 1'b1;
                    end
                    default: w_next = ERROR;
                endcase
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = ALUWB;
            end
            ERROR: begin
                illegal = 1'b1;
            end
            default: begin
                w_next = ERROR;
            end
        endcase

        // Mealy terms would otherwise leak enables while reset is held
        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ALUControl = ALU_ADD;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: instruction table, corner
// sequences and random instructions checked against a per-instruction phase model.
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] ALUControl;
    logic       instr_done, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    unidade_controle_multiciclo dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] srcA, srcB, res;
        logic [3:0] alu;
        logic       done, ill;
    } ctl_t;

    typedef struct {
        logic mr;
        logic zr;
        ctl_t e;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zr;
        int         cycles;
        logic [3:0] endSt;
        logic       endPcw;
    } vec_t;

    ctl_t act;
    assign act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, instr_done, illegal};

    cyc_t q[$];
    vec_t tbl[17];
    int   vecs = 0;
    int   miscompares = 0;

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic ctl_t base(input logic [3:0] st);
        ctl_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic void push(input ctl_t e, input logic mr, input logic zr);
        cyc_t c;
        c.e  = e;
        c.mr = mr;
        c.zr = zr;
        q.push_back(c);
    endfunction

    function automatic void pushAluWb();
        ctl_t c;
        c = base(4'd7);
        c.rw = 1'b1;
        c.done = 1'b1;
        push(c, rb(), rb());
    endfunction

    // Expands one instruction into its expected cycle sequence; returns 1 if it traps
    function automatic bit model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic zr, input int sf, input int sm);
        ctl_t c;
        bit   ok;
        ok = 1'b1;
        c = base(4'd0);
        c.srcB = 2'b10;
        c.res  = 2'b10;
        for (int i = 0; i < sf; i++) push(c, 1'b0, rb());
        c.irw = 1'b1;
        c.pcw = 1'b1;
        push(c, 1'b1, rb());
        c = base(4'd1);
        c.srcA = 2'b01;
        c.srcB = 2'b01;
        push(c, rb(), rb());
        case (op)
            7'b0000011, 7'b0100011: begin
                c = base(4'd2);
                c.srcA = 2'b10;
                c.srcB = 2'b01;
                push(c, rb(), rb());
                if (op == 7'b0000011) begin
                    c = base(4'd3);
                    c.adr = 1'b1;
                    for (int i = 0; i < sm; i++) push(c, 1'b0, rb());
                    push(c, 1'b1, rb());
                    c = base(4'd4);
                    c.res = 2'b01;
                    c.rw = 1'b1;
                    c.done = 1'b1;
                    push(c, rb(), rb());
                end else begin
                    c = base(4'd5);
                    c.adr = 1'b1;
                    c.mw = 1'b1;
                    for (int i = 0; i < sm; i++) push(c, 1'b0, rb());
                    c.done = 1'b1;
                    push(c, 1'b1, rb());
                end
            end
            7'b0110011: begin
                c = base(4'd6);
                c.srcA = 2'b10;
                if (f7 == 7'h00 && f3 == 3'd0)      c.alu = 4'd0;
                else if (f7 == 7'h20 && f3 == 3'd0) c.alu = 4'd1;
                else if (f7 == 7'h00 && f3 == 3'd7) c.alu = 4'd2;
                else if (f7 == 7'h00 && f3 == 3'd6) c.alu = 4'd3;
                else ok = 1'b0;
                push(c, rb(), rb());
                if (ok) pushAluWb();
            end
            7'b0010011: begin
                c = base(4'd8);
                c.srcA = 2'b10;
                c.srcB = 2'b01;
                if (f3 == 3'd0)      c.alu = 4'd0;
                else if (f3 == 3'd7) c.alu = 4'd2;
                else if (f3 == 3'd6) c.alu = 4'd3;
                else ok = 1'b0;
                push(c, rb(), rb());
                if (ok) pushAluWb();
            end
            7'b1100011: begin
                c = base(4'd9);
                c.srcA = 2'b10;
                c.alu = 4'd1;
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    c.done = 1'b1;
                    c.pcw = (f3 == 3'd0) ? zr : !zr;
                end else begin
                    ok = 1'b0;
                end
                push(c, rb(), zr);
            end
            7'b1101111: begin
                c = base(4'd10);
                c.srcA = 2'b01;
                c.srcB = 2'b10;
                c.pcw = 1'b1;
                push(c, rb(), rb());
                pushAluWb();
            end
            default: ok = 1'b0;
        endcase
        return !ok;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecs++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input string tag);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.mr;
            zero = c.zr;
            #2;
            checkOutput($sformatf("%s cycle %0d", tag, n), 32'(act), 32'(c.e));
            n++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset hold", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic doInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic zr, input int sf, input int sm,
                           input int errCycles);
        ctl_t c;
        bit   trap;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        trap = model(op, f3, f7, zr, sf, sm);
        if (trap) begin
            c = base(4'd15);
            c.ill = 1'b1;
            for (int i = 0; i < errCycles; i++) push(c, rb(), rb());
        end
        applyStimulus(tag);
        if (trap) doReset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int         n;
        bit         fin;
        logic [3:0] gotSt;
        logic       gotPcw;
        logic [6:0] rop, rf7;
        logic [2:0] rf3;

        tbl[0]  = '{7'h33, 3'd0, 7'h00, 1'b0, 4, 4'd7,  1'b0};
        tbl[1]  = '{7'h33, 3'd0, 7'h20, 1'b0, 4, 4'd7,  1'b0};
        tbl[2]  = '{7'h33, 3'd7, 7'h00, 1'b0, 4, 4'd7,  1'b0};
        tbl[3]  = '{7'h33, 3'd6, 7'h00, 1'b0, 4, 4'd7,  1'b0};
        tbl[4]  = '{7'h13, 3'd0, 7'h55, 1'b0, 4, 4'd7,  1'b0};
        tbl[5]  = '{7'h13, 3'd7, 7'h00, 1'b0, 4, 4'd7,  1'b0};
        tbl[6]  = '{7'h03, 3'd2, 7'h00, 1'b0, 5, 4'd4,  1'b0};
        tbl[7]  = '{7'h23, 3'd2, 7'h00, 1'b0, 4, 4'd5,  1'b0};
        tbl[8]  = '{7'h63, 3'd0, 7'h00, 1'b1, 3, 4'd9,  1'b1};
        tbl[9]  = '{7'h63, 3'd0, 7'h00, 1'b0, 3, 4'd9,  1'b0};
        tbl[10] = '{7'h63, 3'd1, 7'h00, 1'b0, 3, 4'd9,  1'b1};
        tbl[11] = '{7'h63, 3'd1, 7'h00, 1'b1, 3, 4'd9,  1'b0};
        tbl[12] = '{7'h6F, 3'd0, 7'h00, 1'b0, 4, 4'd7,  1'b0};
        tbl[13] = '{7'h7F, 3'd0, 7'h00, 1'b0, 3, 4'd15, 1'b0};
        tbl[14] = '{7'h33, 3'd0, 7'h01, 1'b0, 4, 4'd15, 1'b0};
        tbl[15] = '{7'h13, 3'd1, 7'h00, 1'b0, 4, 4'd15, 1'b0};
        tbl[16] = '{7'h63, 3'd2, 7'h00, 1'b1, 4, 4'd15, 1'b0};

        reset = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        opcode = 7'h33;
        funct3 = 3'd0;
        funct7 = 7'h00;

        // Reset held three cycles with mem_ready high: nothing may be enabled
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("reset quiet", 32'(act), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        checkOutput("first fetch IRWrite/PCWrite/state", {27'd0, IRWrite, PCWrite, state}, 32'b11_0000);
        @(negedge clk);
        doReset();

        $display("[TB] instruction table");
        for (int i = 0; i < 17; i++) begin
            opcode = tbl[i].op;
            funct3 = tbl[i].f3;
            funct7 = tbl[i].f7;
            zero = tbl[i].zr;
            mem_ready = 1'b1;
            n = 0;
            fin = 1'b0;
            gotSt = 4'd0;
            gotPcw = 1'b0;
            while (!fin && n < 12) begin
                n++;
                #2;
                if (instr_done || illegal) begin
                    fin = 1'b1;
                    gotSt = state;
                    gotPcw = PCWrite;
                end
                @(posedge clk);
                @(negedge clk);
            end
            checkOutput($sformatf("tbl%0d cycles", i), 32'(n), 32'(tbl[i].cycles));
            checkOutput($sformatf("tbl%0d end state", i), 32'(gotSt), 32'(tbl[i].endSt));
            checkOutput($sformatf("tbl%0d end PCWrite", i), 32'(gotPcw), 32'(tbl[i].endPcw));
            if (state != 4'd0) doReset();
        end

        $display("[TB] directed sequences");
        doInstr("add", 7'h33, 3'd0, 7'h00, 1'b0, 0, 0, 0);
        doInstr("sub", 7'h33, 3'd0, 7'h20, 1'b0, 0, 0, 0);
        doInstr("lw stall", 7'h03, 3'd2, 7'h00, 1'b0, 0, 2, 0);
        doInstr("sw stall", 7'h23, 3'd2, 7'h00, 1'b0, 1, 3, 0);
        doInstr("fetch stall", 7'h13, 3'd6, 7'h00, 1'b0, 3, 0, 0);
        doInstr("bad opcode", 7'h7F, 3'd0, 7'h00, 1'b0, 0, 0, 20);
        doInstr("bad funct7", 7'h33, 3'd0, 7'h01, 1'b0, 0, 0, 20);

        // Reset dropped asynchronously in the middle of a load
        opcode = 7'h03;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checkOutput("mid-load state", 32'(state), 32'd3);
        mem_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async reset", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("async reset held", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doInstr("after reset", 7'h33, 3'd7, 7'h00, 1'b0, 0, 0, 0);

        $display("[TB] random instructions");
        for (int k = 0; k < 60; k++) begin
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 7'h00;
            case ($urandom_range(0, 7))
                0: rop = 7'h03;
                1: rop = 7'h23;
                2: begin
                    rop = 7'h33;
                    case ($urandom_range(0, 3))
                        0: rf7 = 7'h20;
                        1: rf7 = 7'h01;
                        default: rf7 = 7'h00;
                    endcase
                end
                3: rop = 7'h13;
                4: begin
                    rop = 7'h63;
                    rf3 = 3'($urandom_range(0, 2));
                end
                5: rop = 7'h6F;
                6: begin
                    rop = 7'h33;
                    rf3 = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd7;
                end
                default: rop = 7'($urandom_range(0, 127));
            endcase
            doInstr($sformatf("rnd%0d", k), rop, rf3, rf7, rb(),
                    $urandom_range(0, 2), $urandom_range(0, 2), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
